// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Default weight of 1 makes the arbiter behave as plain round-robin.
package wrr_pkg;

  localparam int MAX_N = 64;
  localparam int W_DEF = 4;
  localparam int DEF_WEIGHT = 1;

  typedef logic [W_DEF-1:0] weight_t;

  function automatic logic [5:0] onehot_to_idx(
    input logic [MAX_N-1:0] oh
  );
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating find-first-set: first set bit of req at or after ptr.
// Uses a doubled request vector so no modulo logic is needed.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx   = sum[IW-1:0];
    found = |req;
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-owner lock and registered
// one-hot grant, grant index and grant-valid outputs.
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_en,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_lock,
  input  logic [N*W-1:0]  i_weight,
  input  logic            i_weight_load,
  output logic [N-1:0]    o_gnt,
  output logic [IW-1:0]   o_gnt_idx,
  output logic            o_gnt_valid
);

  logic [N-1:0][W-1:0] wgt;
  logic [IW-1:0]       ptr;
  logic [W-1:0]        cnt;
  logic                own_vld;

  logic [N-1:0]        gnt_nxt;
  logic [IW-1:0]       idx_nxt;
  logic                vld_nxt;
  logic [IW-1:0]       ptr_nxt;
  logic [W-1:0]        cnt_nxt;
  logic                own_nxt;

  logic                found;
  logic [IW-1:0]       pick;
  logic [N-1:0]        pick_oh;
  logic [MAX_N-1:0]    oh_ext;
  logic [W-1:0]        pick_w;
  logic                hold;

  rr_pick #(.N(N)) u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    gnt_nxt = o_gnt;
    idx_nxt = o_gnt_idx;
    vld_nxt = o_gnt_valid;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    own_nxt = own_vld;

    pick_oh = N'(1) << pick;
    oh_ext  = '0;
    oh_ext[N-1:0] = pick_oh;
    pick_w  = wgt[pick];
    if (pick_w == '0) pick_w = W'(1);

    hold = own_vld && i_req[o_gnt_idx] &&
           ((cnt != '0) || i_lock[o_gnt_idx]);

    if (hold) begin
      if (cnt != '0) cnt_nxt = cnt - W'(1);
    end else if (found) begin
      gnt_nxt = pick_oh;
      idx_nxt = IW'(onehot_to_idx(oh_ext));
      vld_nxt = 1'b1;
      own_nxt = 1'b1;
      cnt_nxt = pick_w - W'(1);
      ptr_nxt = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
    end else begin
      gnt_nxt = '0;
      vld_nxt = 1'b0;
      own_nxt = 1'b0;
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_gnt       <= '0;
      o_gnt_idx   <= '0;
      o_gnt_valid <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      own_vld     <= 1'b0;
    end else if (i_en) begin
      o_gnt       <= gnt_nxt;
      o_gnt_idx   <= idx_nxt;
      o_gnt_valid <= vld_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      own_vld     <= own_nxt;
    end
  end

  // A zero weight is stored as 1 so credit math never underflows.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < N; k++) wgt[k] <= W'(DEF_WEIGHT);
    end else if (i_weight_load) begin
      for (int k = 0; k < N; k++) begin
        wgt[k] <= (i_weight[k*W +: W] == '0) ?
                  W'(1) : i_weight[k*W +: W];
      end
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed testbench for wrr_arbiter (N=4, W=4).
// Expected grants are hand-computed per step.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  lock;
  logic [N*W-1:0] weight;
  logic          wload;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .W(W)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_en          (en),
    .i_req         (req),
    .i_lock        (lock),
    .i_weight      (weight),
    .i_weight_load (wload),
    .o_gnt         (gnt),
    .o_gnt_idx     (gnt_idx),
    .o_gnt_valid   (gnt_valid)
  );

  function automatic logic [15:0] wts(int w3, int w2, int w1, int w0);
    return {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
  endfunction

  function automatic logic [1:0] idx_of(logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    if (oh[1]) r = 2'd1;
    if (oh[2]) r = 2'd2;
    if (oh[3]) r = 2'd3;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_g(input string tag, input logic [3:0] eg);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(|eg));
    if (eg != 4'b0) chk({tag, ".idx"}, 32'(gnt_idx), 32'(idx_of(eg)));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic load(input logic [15:0] w);
    weight = w;
    wload  = 1'b1;
    tick();
    wload  = 1'b0;
  endtask

  logic [3:0] seq1 [10];

  initial begin
    rstn = 1'b0; en = 1'b1; req = '0; lock = '0;
    weight = '0; wload = 1'b0;
    seq1 = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
             4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0010};
    tick();
    tick();
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.idx", 32'(gnt_idx), 32'h0);
    chk("rst.vld", 32'(gnt_valid), 32'h0);

    // weighted sequence with wrap 3->0
    rstn = 1'b1;
    load(wts(1, 3, 1, 2));
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_g($sformatf("wseq%0d", i), seq1[i]);
    end
    req = 4'b0000;
    tick();
    chk_g("noreq", 4'b0000);

    // default weights alternate
    do_reset();
    req = 4'b1010;
    tick(); chk_g("alt0", 4'b0010);
    tick(); chk_g("alt1", 4'b1000);
    tick(); chk_g("alt2", 4'b0010);
    tick(); chk_g("alt3", 4'b1000);

    // lock keeps owner, lock on non-owner ignored
    do_reset();
    req = 4'b1111; lock = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_g($sformatf("lock%0d", i), 4'b0001);
    end
    lock = 4'b0000;
    tick(); chk_g("unlock", 4'b0010);
    lock = 4'b0001;
    tick(); chk_g("lock_nonowner", 4'b0100);
    lock = 4'b0000;

    // owner drops mid-burst, no gap
    do_reset();
    req = 4'b0000;
    load(wts(1, 3, 1, 1));
    req = 4'b0100;
    tick(); chk_g("drop0", 4'b0100);
    req = 4'b0011;
    tick(); chk_g("drop1", 4'b0001);

    // freeze mid-burst, then reset mid-burst
    do_reset();
    req = 4'b0000;
    load(wts(1, 1, 3, 1));
    req = 4'b0011;
    tick(); chk_g("frz0", 4'b0001);
    tick(); chk_g("frz1", 4'b0010);
    tick(); chk_g("frz2", 4'b0010);
    en = 1'b0; req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_g($sformatf("frozen%0d", i), 4'b0010);
    end
    req = 4'b0011; en = 1'b1;
    tick(); chk_g("frz3", 4'b0010);
    tick(); chk_g("frz4", 4'b0001);
    tick(); chk_g("frz5", 4'b0010);
    rstn = 1'b0; wload = 1'b1; weight = wts(3, 3, 3, 3);
    tick();
    chk("mrst.gnt", 32'(gnt), 32'h0);
    chk("mrst.idx", 32'(gnt_idx), 32'h0);
    chk("mrst.vld", 32'(gnt_valid), 32'h0);
    rstn = 1'b1; wload = 1'b0;
    tick(); chk_g("mrst0", 4'b0001);
    tick(); chk_g("mrst1", 4'b0010);
    tick(); chk_g("mrst2", 4'b0001);

    // weight load during an active burst
    do_reset();
    req = 4'b0000;
    load(wts(1, 1, 1, 2));
    req = 4'b0011;
    tick(); chk_g("wl0", 4'b0001);
    weight = wts(1, 1, 1, 4); wload = 1'b1;
    tick(); chk_g("wl1", 4'b0001);
    wload = 1'b0;
    tick(); chk_g("wl2", 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_g($sformatf("wl_new%0d", i), 4'b0001);
    end
    tick(); chk_g("wl_end", 4'b0010);

    // zero weight acts as 1
    do_reset();
    req = 4'b0000;
    load(wts(0, 0, 0, 0));
    req = 4'b0011;
    tick(); chk_g("w0_0", 4'b0001);
    tick(); chk_g("w0_1", 4'b0010);
    tick(); chk_g("w0_2", 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter; next generation of the single-cycle round_robin arbiter.
- Each requester holds the grant for up to a programmable number of consecutive cycles (its weight). Priority then rotates to the next requester.
- Adds a lock input so a master can keep the grant for atomic bursts, and reports an encoded grant index.
- Sits between N bus masters and a shared resource; registered outputs.

Parameters:
- N, 8, number of requesters (>=2).
- W, 4, width of each per-requester weight field.
- IW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_en  in  1  arbitration enable; 0 freezes all state
- i_req  in  N  request vector, bit k = requester k
- i_lock  in  N  per-requester lock; honoured only for the current owner
- i_weight  in  N*W  packed weights, field k = bits [k*W +: W]
- i_weight_load  in  1  capture i_weight into internal weight registers
- o_gnt  out  N  one-hot registered grant (all zero = no grant)
- o_gnt_idx  out  IW  index of granted requester (valid when o_gnt_valid)
- o_gnt_valid  out  1  OR-reduction of o_gnt, registered

Behaviour:
- Reset (i_rstn=0 at posedge):
  - o_gnt=0, o_gnt_idx=0, o_gnt_valid=0.
  - Pointer ptr=0, credit cnt=0, owner invalid.
  - All weight registers = 1, giving plain round-robin.
- Reset mid-burst drops the grant on that edge. It has priority over i_en and i_weight_load.
- Weight load:
  - On the posedge with i_weight_load=1, the weight registers update, independent of i_en.
  - A weight of 0 is treated as 1.
  - The new weights apply only to grants issued after the load; a running credit is not altered.
- i_en=0: all registers, including o_gnt, hold their value.
- Per posedge with i_en=1, the decision uses the current i_req/i_lock, and the result appears on o_gnt after that edge (1-cycle latency).
- HOLD: the owner is valid and i_req[owner]=1 and (cnt>0 or i_lock[owner]=1).
  - o_gnt unchanged.
  - cnt decrements, saturating at 0.
- ARBITRATE: otherwise.
  - Search i_req circularly starting at ptr; the first set bit k wins.
  - o_gnt=1<<k, o_gnt_idx=k, cnt=max(weight[k],1)-1, ptr=(k+1) mod N with wrap N-1 -> 0.
  - If the owner's request is still set but its credit is expired, the owner is skipped this round only if another requester is pending; otherwise it is re-granted with fresh credit.
  - This falls out naturally because ptr already points past the owner.
- No request: o_gnt=0, o_gnt_valid=0, owner invalid, ptr unchanged, cnt=0.
- If the owner drops i_req, the re-arbitration on that same edge excludes it. There are no idle gap cycles.
- i_lock on a non-owner has no effect.
- Starvation bound: a pending unlocked requester is granted within sum of the other weights + 1 cycles.
- Arithmetic: cnt is W bits wide. The rotate search operates on a 2N-bit concatenation; no divide or modulo logic.
- Invariants: o_gnt is always one-hot or zero; o_gnt_idx matches o_gnt.

Decomposition:
- Package wrr_pkg:
  - Weight typedef logic [W-1:0].
  - Function onehot_to_idx.
  - A localparam for the default weight (1).
- Sub-module rr_pick:
  - Combinational; inputs req[N] and ptr[IW].
  - Outputs found and idx[IW] (rotating find-first-set).
  - Instantiated once; reusable by the original arbiter.

Test Plan:
- N=4, W=4, weights {w3..w0}={1,3,1,2} loaded, i_req=1111 held, i_lock=0: o_gnt sequence after load = 0001,0001,0010,0100,0100,0100,1000,0001,0001,0010 (checks credits and wrap 3->0).
- Default weights after reset, i_req=1010: o_gnt alternates 0010,1000,0010,1000; o_gnt_idx alternates 1,3.
- Weights all 1, owner=0 with i_lock=0001 and i_req=1111 for 5 cycles: o_gnt stays 0001. On the edge i_lock clears, o_gnt=0010 on the next edge.
- During a weight-3 grant to requester 2, i_req[2] drops after 1 cycle with i_req=0011 pending: the next edge grants 0001 (ptr=3 wraps). The drop edge leaves no zero-grant gap.
- i_en=0 for 3 cycles mid-burst: o_gnt/cnt frozen. After re-enable the burst completes its remaining credit. i_rstn=0 mid-burst: o_gnt=0000, weights back to 1 on the next edge.
- i_weight_load during an active weight-2 grant to requester 0 (new w0=4): current burst ends after 2 cycles; the next grant to requester 0 lasts 4 cycles.
